// File: rtl/fletcher_frame_appender_pkg.sv
// Shared definitions for the Fletcher frame appender: FSM state encoding,
// the Fletcher modulus helper and the checksum word-order constant.
package fletcher_frame_appender_pkg;

    // Appender phases: forwarding payload, emitting the high checksum word,
    // emitting the low checksum word.
    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_CK_HI = 2'd1,
        ST_CK_LO = 2'd2
    } state_e;

    // Checksum word order on the wire is {B, A}: B leaves first, A closes the frame.
    localparam logic CK_FIRST_IS_B = 1'b1;

    // Fletcher modulus for a given word width: 2^width - 1.
    function automatic longint unsigned fletcher_modulus(input int word_width);
        return (64'd1 << word_width) - 64'd1;
    endfunction

endpackage

// File: rtl/fletcher_accum.sv
// Fletcher running-sum pair (A, B) kept in 0..M-1 with M = 2^WordWidth-1.
// clr has priority over en so a frame can close and reopen cleanly.
module fletcher_accum
    import fletcher_frame_appender_pkg::*;
#(
    parameter int WordWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WordWidth-1:0] d,
    output logic [WordWidth-1:0] a,
    output logic [WordWidth-1:0] b
);

    localparam int SumWidth = WordWidth + 1;
    localparam logic [SumWidth-1:0] Modulus = SumWidth'(fletcher_modulus(WordWidth));

    // One's-complement style add: both operands are at most M, so a single
    // conditional subtract brings the result back into 0..M-1 (d = M adds 0).
    function automatic logic [WordWidth-1:0] mod_add(
        input logic [WordWidth-1:0] x,
        input logic [WordWidth-1:0] y
    );
        logic [SumWidth-1:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= Modulus) begin
            sum = sum - Modulus;
        end else begin
            sum = sum;
        end
        return sum[WordWidth-1:0];
    endfunction

    logic [WordWidth-1:0] a_r;
    logic [WordWidth-1:0] b_r;
    logic [WordWidth-1:0] a_nxt_s;
    logic [WordWidth-1:0] b_nxt_s;

    // Next A then B, B folding in the freshly updated A.
    always_comb begin
        a_nxt_s = mod_add(a_r, d);
        b_nxt_s = mod_add(b_r, a_nxt_s);
    end

    // Accumulator registers: clear wins over update, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {WordWidth{1'b0}};
            b_r <= {WordWidth{1'b0}};
        end else if (clr) begin
            a_r <= {WordWidth{1'b0}};
            b_r <= {WordWidth{1'b0}};
        end else if (en) begin
            a_r <= a_nxt_s;
            b_r <= b_nxt_s;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    assign a = a_r;
    assign b = b_r;

endmodule

// File: rtl/fletcher_frame_appender.sv
// Streaming stage that forwards payload words unchanged and appends the
// Fletcher checksum {B, A} as two trailing words after each in_last word.
// Optional build macro FLETCHER_FRAMECOUNT_EN adds a 16-bit count of frames
// whose closing checksum word has been taken downstream.
module fletcher_frame_appender
    import fletcher_frame_appender_pkg::*;
#(
    parameter  int ChecksumWidth = 16,
    localparam int WordWidth     = ChecksumWidth / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WordWidth-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WordWidth-1:0] out_data,
    output logic                 out_last
`ifdef FLETCHER_FRAMECOUNT_EN
    ,
    output logic [15:0]          frame_count
`endif
);

    state_e               state_r;
    state_e               state_nxt_s;

    logic                 out_valid_r;
    logic [WordWidth-1:0] out_data_r;
    logic                 out_last_r;

    logic                 load_ok_s;
    logic                 in_ready_s;
    logic                 accept_s;

    logic                 ld_word_s;
    logic [WordWidth-1:0] word_s;
    logic                 last_s;
    logic                 valid_nxt_s;
    logic                 acc_en_s;
    logic                 acc_clr_s;

    logic [WordWidth-1:0] acc_a_s;
    logic [WordWidth-1:0] acc_b_s;
    logic [WordWidth-1:0] hi_word_s;
    logic [WordWidth-1:0] lo_word_s;

    fletcher_accum #(
        .WordWidth(WordWidth)
    ) u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_en_s),
        .clr   (acc_clr_s),
        .d     (in_data),
        .a     (acc_a_s),
        .b     (acc_b_s)
    );

    // Handshake qualifiers: the single output register can load when empty
    // or draining; input is only taken while forwarding and out of reset.
    always_comb begin
        load_ok_s  = !out_valid_r || out_ready;
        in_ready_s = (state_r == ST_PASS) && load_ok_s && rst_n;
        accept_s   = in_valid && in_ready_s;
        hi_word_s  = CK_FIRST_IS_B ? acc_b_s : acc_a_s;
        lo_word_s  = CK_FIRST_IS_B ? acc_a_s : acc_b_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PASS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: close the frame on the accepted last word, then step
    // through the two checksum words as the output register frees up.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_PASS: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_CK_HI;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_CK_HI: begin
                if (load_ok_s) begin
                    state_nxt_s = ST_CK_LO;
                end else begin
                    state_nxt_s = ST_CK_HI;
                end
            end
            ST_CK_LO: begin
                if (load_ok_s) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_CK_LO;
                end
            end
            default: begin
                state_nxt_s = ST_PASS;
            end
        endcase
    end

    // Output decode: what the output register loads this cycle and how the
    // accumulators move.
    always_comb begin
        ld_word_s   = 1'b0;
        word_s      = {WordWidth{1'b0}};
        last_s      = 1'b0;
        valid_nxt_s = out_valid_r;
        acc_en_s    = 1'b0;
        acc_clr_s   = 1'b0;
        case (state_r)
            ST_PASS: begin
                if (accept_s) begin
                    ld_word_s   = 1'b1;
                    word_s      = in_data;
                    last_s      = 1'b0;
                    valid_nxt_s = 1'b1;
                    acc_en_s    = 1'b1;
                end else if (load_ok_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = out_valid_r;
                end
            end
            ST_CK_HI: begin
                if (load_ok_s) begin
                    ld_word_s   = 1'b1;
                    word_s      = hi_word_s;
                    last_s      = 1'b0;
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = out_valid_r;
                end
            end
            ST_CK_LO: begin
                if (load_ok_s) begin
                    ld_word_s   = 1'b1;
                    word_s      = lo_word_s;
                    last_s      = 1'b1;
                    valid_nxt_s = 1'b1;
                    acc_clr_s   = 1'b1;
                end else begin
                    valid_nxt_s = out_valid_r;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output register: data/last only change on a load so they stay stable
    // while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WordWidth{1'b0}};
            out_last_r  <= 1'b0;
        end else if (ld_word_s) begin
            out_valid_r <= valid_nxt_s;
            out_data_r  <= word_s;
            out_last_r  <= last_s;
        end else begin
            out_valid_r <= valid_nxt_s;
            out_data_r  <= out_data_r;
            out_last_r  <= out_last_r;
        end
    end

`ifdef FLETCHER_FRAMECOUNT_EN
    logic [15:0] frame_count_r;

    // Frame counter: bumps when the closing checksum word is taken; wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_r <= 16'd0;
        end else if (out_valid_r && out_ready && out_last_r) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_fletcher_frame_appender.sv
// Self-checking bench for fletcher_frame_appender (default 16-bit checksum,
// 8-bit words). Expected streams come from literal vectors or from a plain
// arithmetic Fletcher model.
module tb_fletcher_frame_appender;

    typedef logic [7:0] byte_q_t[$];

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
`ifdef FLETCHER_FRAMECOUNT_EN
    logic [15:0] frame_count;
`endif

    int vectors;
    int miscompares;
    int stab_viol;
    int timed_out;
    int drv_timeout;
    logic [7:0] got_data[$];
    logic       got_last[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];

    fletcher_frame_appender #(.ChecksumWidth(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef FLETCHER_FRAMECOUNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Fletcher-16 over bytes, payload then B then A.
    function automatic void model_frame(input byte_q_t w);
        int a;
        int b;
        a = 0;
        b = 0;
        for (int i = 0; i < w.size(); i++) begin
            a = (a + int'(w[i])) % 255;
            b = (b + a) % 255;
            exp_data.push_back(w[i]);
            exp_last.push_back(1'b0);
        end
        exp_data.push_back(8'(b));
        exp_last.push_back(1'b0);
        exp_data.push_back(8'(a));
        exp_last.push_back(1'b1);
    endfunction

    // Feed one frame starting at a negedge; random idle gaps with junk data.
    task automatic drive(input byte_q_t w, input bit mark_last, input int gap_pct);
        int waited;
        for (int i = 0; i < w.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = mark_last && (i == w.size() - 1);
            waited   = 0;
            forever begin
                #2;
                if (in_ready) begin
                    @(posedge clk);
                    break;
                end
                if (waited >= 2000) begin
                    drv_timeout++;
                    break;
                end
                waited++;
                @(negedge clk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Capture transferred beats; randomize out_ready and note any change of a
    // stalled output word.
    task automatic collect(input int nbeats, input int ready_pct, input int max_cycles);
        int         cyc;
        logic       held_v;
        logic [7:0] held_d;
        logic       held_l;
        cyc    = 0;
        held_v = 1'b0;
        held_d = 8'd0;
        held_l = 1'b0;
        got_data.delete();
        got_last.delete();
        stab_viol = 0;
        timed_out = 0;
        while (got_data.size() < nbeats) begin
            if (cyc >= max_cycles) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            cyc++;
            #1;
            if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l)) begin
                stab_viol++;
            end
            out_ready = (int'($urandom_range(99)) < ready_pct);
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5a;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b, want 0 00 0", out_valid, out_data, out_last);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, want 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    // One or two frames against a literal expected byte stream.
    task automatic test_frames(input string name, input byte_q_t f1, input byte_q_t f2,
                               input byte_q_t want, input int ready_pct, input int gap_pct);
        int   n;
        logic wl;
        n = want.size();
        drv_timeout = 0;
        fork
            begin
                drive(f1, 1'b1, gap_pct);
                if (f2.size() > 0) drive(f2, 1'b1, gap_pct);
            end
            collect(n, ready_pct, 5000);
        join
        vectors++;
        if (timed_out != 0 || drv_timeout != 0 || got_data.size() != n) begin
            miscompares++;
            $display("FAIL %s_count: got %0d beats, want %0d", name, got_data.size(), n);
        end
        for (int i = 0; i < got_data.size() && i < n; i++) begin
            wl = (i == f1.size() + 1) || (i == n - 1);
            vectors++;
            if (got_data[i] !== want[i] || got_last[i] !== wl) begin
                miscompares++;
                $display("FAIL %s_beat%0d: got %h/last=%b, want %h/last=%b", name, i, got_data[i], got_last[i], want[i], wl);
            end
        end
        vectors++;
        if (stab_viol != 0) begin
            miscompares++;
            $display("FAIL %s_stable: got %0d changes while stalled, want 0", name, stab_viol);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: got out_valid=%b after frame, want 0", name, out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        byte_q_t part;
        byte_q_t one;
        byte_q_t none;
        byte_q_t want;
        part = '{8'h61, 8'h62, 8'h63};
        one  = '{8'h01};
        none = {};
        want = '{8'h01, 8'h01, 8'h01};
        out_ready = 1'b1;
        @(negedge clk);
        drive(part, 1'b0, 0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h64;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset: got out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        test_frames("midreset_one", one, none, want, 100, 0);
    endtask

    task automatic test_random();
        byte_q_t frames[6];
        int      total;
        int      n;
        exp_data.delete();
        exp_last.delete();
        total = 0;
        for (int f = 0; f < 6; f++) begin
            frames[f] = {};
            n = int'($urandom_range(10, 1));
            for (int k = 0; k < n; k++) frames[f].push_back(8'($urandom));
            if (f == 2) frames[f].push_back(8'hff);
            model_frame(frames[f]);
            total += frames[f].size() + 2;
        end
        drv_timeout = 0;
        fork
            begin
                for (int f = 0; f < 6; f++) drive(frames[f], 1'b1, 30);
            end
            collect(total, 50, 20000);
        join
        vectors++;
        if (timed_out != 0 || drv_timeout != 0 || got_data.size() != total) begin
            miscompares++;
            $display("FAIL random_count: got %0d beats, want %0d", got_data.size(), total);
        end
        for (int i = 0; i < got_data.size() && i < total; i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL random_beat%0d: got %h/last=%b, want %h/last=%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        vectors++;
        if (stab_viol != 0) begin
            miscompares++;
            $display("FAIL random_stable: got %0d changes while stalled, want 0", stab_viol);
        end
        out_ready = 1'b1;
    endtask

`ifdef FLETCHER_FRAMECOUNT_EN
    task automatic test_framecount();
        byte_q_t one;
        one = '{8'h01};
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL framecount_reset: got %0d, want 0", frame_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        fork
            begin
                for (int f = 0; f < 3; f++) drive(one, 1'b1, 0);
            end
            collect(9, 100, 500);
        join
        repeat (2) @(negedge clk);
        vectors++;
        if (frame_count !== 16'd3) begin
            miscompares++;
            $display("FAIL framecount_three: got %0d, want 3", frame_count);
        end
    endtask
`endif

    initial begin
        byte_q_t abcde;
        byte_q_t abcdefgh;
        byte_q_t abcdef;
        byte_q_t none;
        byte_q_t b01;
        byte_q_t bff;
        vectors     = 0;
        miscompares = 0;
        drv_timeout = 0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        rst_n       = 1'b0;
        abcde    = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        abcdefgh = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        abcdef   = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        none     = {};
        b01      = '{8'h01};
        bff      = '{8'hff};

        test_reset();
        test_frames("abcde", abcde, none,
                    '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'hc8, 8'hf0}, 100, 0);
        test_frames("abcdefgh", abcdefgh, none,
                    '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h06, 8'h27}, 100, 0);
        test_frames("abcdef", abcdef, none,
                    '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h20, 8'h57}, 100, 0);
        test_frames("back_to_back", b01, bff,
                    '{8'h01, 8'h01, 8'h01, 8'hff, 8'h00, 8'h00}, 100, 0);
        test_frames("abcde_stall", abcde, none,
                    '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'hc8, 8'hf0}, 50, 40);
        test_reset_midframe();
        test_random();
`ifdef FLETCHER_FRAMECOUNT_EN
        test_framecount();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
